// File: rtl/ineq_test_pkg.sv
// Shared types and golden function for the 4-bit inequality comparator sweep tester.
package ineq_test_pkg;

  localparam int NUM_W = 4;
  localparam int OUT_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    FINISH = 3'd4
  } state_t;

  // Expected comparator response: {num < thresh, num > thresh, num == thresh}.
  function automatic logic [OUT_W-1:0] golden_out(input logic [NUM_W-1:0] num,
                                                   input logic [NUM_W-1:0] thresh);
    golden_out = {(num < thresh), (num > thresh), (num == thresh)};
  endfunction

endpackage

// File: rtl/ineq_golden_model.sv
// Combinational golden model of the inequality comparator; also usable from sim benches.
module ineq_golden_model
  import ineq_test_pkg::*;
(
  input  logic [NUM_W-1:0] num,
  input  logic [NUM_W-1:0] thresh,
  output logic [OUT_W-1:0] exp_out
);

  assign exp_out = golden_out(num, thresh);

endmodule

// File: rtl/inequality_sweep_tester.sv
// On-chip sweep tester for the 4-bit inequality comparator: drives 0..15, checks each response.
// Optional build macro INEQ_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module inequality_sweep_tester
  import ineq_test_pkg::*;
#(
  parameter int THRESH        = 10,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [NUM_W-1:0] dut_num,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [4:0]       fail_count,
  output logic [NUM_W-1:0] first_fail_num
);

  localparam logic [NUM_W-1:0] THRESH_V     = THRESH[NUM_W-1:0];
  localparam int               SETTLE_LAST_I = (SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0;
  localparam logic [3:0]       SETTLE_LAST  = SETTLE_LAST_I[3:0];
  localparam logic             SKIP_SETTLE  = (SETTLE_CYCLES == 0) ? 1'b1 : 1'b0;
`ifdef INEQ_STOP_ON_FAIL_EN
  localparam logic             STOP_EN      = 1'b1;
`else
  localparam logic             STOP_EN      = 1'b0;
`endif

  state_t           state_r, state_s;
  logic [3:0]       settle_cnt_r, settle_cnt_s;
  logic [NUM_W-1:0] dut_num_s, first_fail_s;
  logic [4:0]       fail_count_s;
  logic             busy_s, done_s, pass_s;
  logic [OUT_W-1:0] expected_s;
  logic             mismatch_s;

  ineq_golden_model u_golden (
    .num     (dut_num),
    .thresh  (THRESH_V),
    .exp_out (expected_s)
  );

  // Case inequality so an X/Z response from the comparator is never accepted.
  assign mismatch_s = (dut_out !== expected_s);

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_s      = state_r;
    settle_cnt_s = settle_cnt_r;
    dut_num_s    = dut_num;
    fail_count_s = fail_count;
    first_fail_s = first_fail_num;
    busy_s       = busy;
    done_s       = done;
    pass_s       = pass;
    case (state_r)
      IDLE, FINISH: begin
        if (start) begin
          state_s      = DRIVE;
          dut_num_s    = 4'd0;
          fail_count_s = 5'd0;
          first_fail_s = 4'd0;
          done_s       = 1'b0;
          pass_s       = 1'b0;
          busy_s       = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      DRIVE: begin
        settle_cnt_s = 4'd0;
        if (SKIP_SETTLE) begin
          state_s = CHECK;
        end else begin
          state_s = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_r == SETTLE_LAST) begin
          state_s = CHECK;
        end else begin
          settle_cnt_s = settle_cnt_r + 4'd1;
        end
      end
      CHECK: begin
        if (mismatch_s) begin
          fail_count_s = fail_count + 5'd1;
          if (fail_count == 5'd0) begin
            first_fail_s = dut_num;
          end else begin
            first_fail_s = first_fail_num;
          end
        end else begin
          fail_count_s = fail_count;
        end
        // Last vector (or early stop) finishes; otherwise step to the next vector without wrapping.
        if ((dut_num == 4'd15) || (STOP_EN && mismatch_s)) begin
          state_s = FINISH;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (fail_count_s == 5'd0);
        end else begin
          dut_num_s = dut_num + 4'd1;
          state_s   = DRIVE;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        pass_s  = 1'b0;
      end
    endcase
  end

  // State, counters and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      settle_cnt_r   <= 4'd0;
      dut_num        <= 4'd0;
      fail_count     <= 5'd0;
      first_fail_num <= 4'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      state_r        <= state_s;
      settle_cnt_r   <= settle_cnt_s;
      dut_num        <= dut_num_s;
      fail_count     <= fail_count_s;
      first_fail_num <= first_fail_s;
      busy           <= busy_s;
      done           <= done_s;
      pass           <= pass_s;
    end
  end

endmodule

// File: tb/tb_inequality_sweep_tester.sv
// Randomized bench: three testers (settle 0, 1, 3) beside a comparator model with injectable faults.
module tb_inequality_sweep_tester;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [15:0] fault_mask;
  logic [2:0]  flip [16];

  wire [2:0][3:0] dn;
  wire [2:0][2:0] dout;
  wire [2:0]      busy, done, pass;
  wire [2:0][4:0] fc;
  wire [2:0][3:0] ffn;

  int n_checks = 0;
  int n_pass   = 0;
  int done_at [3];

`ifdef INEQ_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int S = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    inequality_sweep_tester #(.THRESH(10), .SETTLE_CYCLES(S)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .dut_num        (dn[g]),
      .dut_out        (dout[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .pass           (pass[g]),
      .fail_count     (fc[g]),
      .first_fail_num (ffn[g])
    );
    // Comparator under test: correct response, corrupted on faulty inputs.
    assign dout[g] = {(dn[g] < 4'd10), (dn[g] > 4'd10), (dn[g] == 4'd10)}
                     ^ (fault_mask[dn[g]] ? flip[dn[g]] : 3'b000);
  end

  function automatic int settle_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
  endfunction

  task automatic check_eq(input string tag, input int g, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s [settle=%0d]: got %0d expected %0d", tag, settle_of(g), obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Pulses start, runs 100 cycles, optional stray start at cycle extra; checks against the model.
  task automatic run_sweep(input int extra);
    int exp_fc, exp_ffn, exp_last, exp_vecs;
    exp_fc = 0; exp_ffn = 0; exp_last = 15; exp_vecs = 16;
    for (int i = 0; i < 16; i++) begin
      if (fault_mask[i]) begin
        if (exp_fc == 0) exp_ffn = i;
        exp_fc++;
        if (STOP) begin
          exp_last = i;
          exp_vecs = i + 1;
          break;
        end
      end
    end
    for (int g = 0; g < 3; g++) done_at[g] = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      check_eq("busy_after_start", g, 32'(busy[g]), 32'd1);
      check_eq("done_cleared", g, 32'(done[g]), 32'd0);
      check_eq("num_reload", g, 32'(dn[g]), 32'd0);
    end
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk); start = (n == extra);
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++)
        if (done[g] && done_at[g] < 0) done_at[g] = n;
    end
    @(negedge clk); start = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check_eq("done_edge", g, 32'(done_at[g]), 32'(exp_vecs * (2 + settle_of(g))));
      check_eq("done_held", g, 32'(done[g]), 32'd1);
      check_eq("busy_end", g, 32'(busy[g]), 32'd0);
      check_eq("pass", g, 32'(pass[g]), 32'(exp_fc == 0));
      check_eq("fail_count", g, 32'(fc[g]), 32'(exp_fc));
      check_eq("first_fail_num", g, 32'(ffn[g]), 32'(exp_ffn));
      check_eq("final_num", g, 32'(dn[g]), 32'(exp_last));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fault_mask = 16'h0000;
    for (int i = 0; i < 16; i++) flip[i] = 3'b001;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      check_eq("reset_num", g, 32'(dn[g]), 32'd0);
      check_eq("reset_busy", g, 32'(busy[g]), 32'd0);
      check_eq("reset_done", g, 32'(done[g]), 32'd0);
      check_eq("reset_pass", g, 32'(pass[g]), 32'd0);
      check_eq("reset_fc", g, 32'(fc[g]), 32'd0);
      check_eq("reset_ffn", g, 32'(ffn[g]), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    // Clean comparator.
    run_sweep(0);
    // Stuck OUT[0] on NUM 13 and 14.
    fault_mask = 16'h6000;
    run_sweep(0);
    // Stray START mid-sweep is ignored.
    fault_mask = 16'h0000;
    run_sweep(10);
    // Single fault at NUM 5.
    fault_mask = 16'h0020;
    run_sweep(0);

    // Reset mid-sweep clears everything at once.
    fault_mask = 16'h0000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check_eq("abort_num", g, 32'(dn[g]), 32'd0);
      check_eq("abort_busy", g, 32'(busy[g]), 32'd0);
      check_eq("abort_done", g, 32'(done[g]), 32'd0);
      check_eq("abort_fc", g, 32'(fc[g]), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    run_sweep(0);

    // Randomized fault patterns, flips and stray starts.
    for (int t = 0; t < 12; t++) begin
      case ($urandom_range(0, 3))
        0:       fault_mask = 16'h0000;
        1:       fault_mask = 16'(1 << $urandom_range(0, 15));
        default: fault_mask = 16'($urandom);
      endcase
      for (int i = 0; i < 16; i++) flip[i] = 3'($urandom_range(1, 7));
      run_sweep(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
